// File: rtl/seq_detect_fsm.sv
// Serial N-bit pattern detector with Mealy/Moore hit outputs
// and a saturating hit counter; transition table built from PATTERN.
module seq_detect_fsm #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             din_valid,
  input  logic             din,
  output logic             mealy_hit,
  output logic             moore_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [SW-1:0]    state
);

  localparam logic [SW-1:0] S_MATCH = SW'(N);
  localparam int            TBL     = 2**SW;

  // Longest j <= min(k+1, N) such that the tail of (prefix_k, x)
  // equals the first j pattern bits.
  function automatic logic [SW-1:0] step(input int k, input logic x);
    int   best;
    int   i;
    logic ok;
    logic b;
    best = 0;
    for (int j = 1; j <= N; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int m = 0; m < N; m++) begin
          if (m < j) begin
            i = k + 1 - j + m;
            b = (i < k) ? PATTERN[N-1-i] : x;
            if (b != PATTERN[N-1-m]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best[SW-1:0];
  endfunction

  logic [SW-1:0] nxt0 [TBL];
  logic [SW-1:0] nxt1 [TBL];

  for (genvar k = 0; k < TBL; k++) begin : g_tbl
    localparam int KE = (k == N && !OVERLAP) ? 0 : k;
    localparam logic [SW-1:0] T0 = (k > N) ? '0 : step(KE, 1'b0);
    localparam logic [SW-1:0] T1 = (k > N) ? '0 : step(KE, 1'b1);
    assign nxt0[k] = T0;
    assign nxt1[k] = T1;
  end

  logic [SW-1:0] nxt;
  logic          adv;
  logic          cnt_full;

  assign nxt       = din ? nxt1[state] : nxt0[state];
  assign adv       = din_valid & ~clear;
  assign mealy_hit = adv & (nxt == S_MATCH);
  assign cnt_full  = &hit_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= '0;
      moore_hit <= 1'b0;
      hit_count <= '0;
    end else if (clear) begin
      state     <= '0;
      moore_hit <= 1'b0;
      hit_count <= '0;
    end else if (din_valid) begin
      state     <= nxt;
      moore_hit <= (nxt == S_MATCH);
      if (mealy_hit && !cnt_full)
        hit_count <= hit_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: three configurations driven in lockstep,
// checked against vector tables, directed sequences and a history model.
module tb_seq_detect_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;

  always #5 clk = ~clk;

  logic       mh_a, moh_a, mh_b, moh_b, mh_c, moh_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [2:0] st_a, st_b;
  logic [1:0] st_c;

  seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid),
    .din(din), .mealy_hit(mh_a), .moore_hit(moh_a),
    .hit_count(cnt_a), .state(st_a));

  seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid),
    .din(din), .mealy_hit(mh_b), .moore_hit(moh_b),
    .hit_count(cnt_b), .state(st_b));

  seq_detect_fsm #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid),
    .din(din), .mealy_hit(mh_c), .moore_hit(moh_c),
    .hit_count(cnt_c), .state(st_c));

  int mh[3], moh[3], hc[3], st[3];
  always_comb begin
    mh[0] = int'(mh_a); mh[1] = int'(mh_b); mh[2] = int'(mh_c);
    moh[0] = int'(moh_a); moh[1] = int'(moh_b); moh[2] = int'(moh_c);
    hc[0] = int'(cnt_a); hc[1] = int'(cnt_b); hc[2] = int'(cnt_c);
    st[0] = int'(st_a); st[1] = int'(st_b); st[2] = int'(st_c);
  end

  int          pn   [3] = '{4, 4, 2};
  logic [15:0] pat  [3] = '{16'hb, 16'hb, 16'h3};
  bit          ovl  [3] = '{1'b1, 1'b0, 1'b1};
  int          cmax [3] = '{255, 255, 3};

  // Model: recent valid-bit history (newest in bit 0) since restart.
  logic [15:0] hbits [3];
  int          hlen  [3];
  bit          pend  [3];
  int          mst   [3];
  int          mcnt  [3];

  int tests = 0;
  int failed = 0;
  int obs_m [3];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int longest(input logic [15:0] h, input int len,
                                 input int n, input logic [15:0] p);
    bit ok;
    for (int j = 16; j >= 1; j--) begin
      if (j <= n && j <= len) begin
        ok = 1'b1;
        for (int m = 0; m < 16; m++)
          if (m < j && h[j-1-m] != p[n-1-m]) ok = 1'b0;
        if (ok) return j;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hbits[i] = '0; hlen[i] = 0; pend[i] = 0; mst[i] = 0; mcnt[i] = 0;
    end
  endtask

  task automatic model(input int i, input bit c, input bit v, input bit d,
                       input bit commit, output bit hit);
    logic [15:0] h;
    int len, s, n;
    bit p;
    h = hbits[i]; len = hlen[i]; p = pend[i]; s = mst[i]; n = mcnt[i];
    hit = 1'b0;
    if (c) begin
      h = '0; len = 0; p = 0; s = 0; n = 0;
    end else if (v) begin
      if (p) begin h = '0; len = 0; p = 0; end
      h = {h[14:0], d};
      if (len < 16) len++;
      s = longest(h, len, pn[i], pat[i]);
      hit = (s == pn[i]);
      if (hit && n < cmax[i]) n++;
      if (hit && !ovl[i]) p = 1;
    end
    if (commit) begin
      hbits[i] = h; hlen[i] = len; pend[i] = p; mst[i] = s; mcnt[i] = n;
    end
  endtask

  task automatic cycle(input bit c, input bit v, input bit d);
    bit h;
    @(negedge clk);
    clear = c; din_valid = v; din = d;
    #1;
    for (int i = 0; i < 3; i++) begin
      model(i, c, v, d, 1'b0, h);
      obs_m[i] = mh[i];
      check($sformatf("mealy[%0d]", i), mh[i], int'(h));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model(i, c, v, d, 1'b1, h);
      check($sformatf("state[%0d]", i), st[i], mst[i]);
      check($sformatf("moore[%0d]", i), moh[i], int'(mst[i] == pn[i]));
      check($sformatf("count[%0d]", i), hc[i], mcnt[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clear = 1'b0; din_valid = 1'b0; din = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit d;
    bit ma; int sa; int ca;
    bit mb; int sb; int cb;
    bit mc; int sc; int cc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 2, 0, 0, 2, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 3, 0, 0, 3, 0, 0, 1, 0};
    tbl[3] = '{1, 1, 4, 1, 1, 4, 1, 1, 2, 1};
    tbl[4] = '{0, 0, 2, 1, 0, 0, 1, 0, 0, 1};
    tbl[5] = '{1, 0, 3, 1, 0, 1, 1, 0, 1, 1};
    tbl[6] = '{1, 1, 4, 2, 0, 1, 1, 1, 2, 2};

    model_reset();
    #2;
    check("reset_state_a", st[0], 0);
    check("reset_moore_a", moh[0], 0);
    check("reset_count_a", hc[0], 0);
    check("reset_mealy_c", mh[2], 0);
    do_reset();

    for (int r = 0; r < 7; r++) begin
      cycle(1'b0, 1'b1, tbl[r].d);
      check($sformatf("tbl%0d_mealy_a", r), obs_m[0], int'(tbl[r].ma));
      check($sformatf("tbl%0d_state_a", r), st[0], tbl[r].sa);
      check($sformatf("tbl%0d_moore_a", r), moh[0], int'(tbl[r].sa == 4));
      check($sformatf("tbl%0d_count_a", r), hc[0], tbl[r].ca);
      check($sformatf("tbl%0d_mealy_b", r), obs_m[1], int'(tbl[r].mb));
      check($sformatf("tbl%0d_state_b", r), st[1], tbl[r].sb);
      check($sformatf("tbl%0d_count_b", r), hc[1], tbl[r].cb);
      check($sformatf("tbl%0d_mealy_c", r), obs_m[2], int'(tbl[r].mc));
      check($sformatf("tbl%0d_state_c", r), st[2], tbl[r].sc);
      check($sformatf("tbl%0d_count_c", r), hc[2], tbl[r].cc);
    end

    // Gaps of invalid cycles hold the state at S2.
    do_reset();
    cycle(0, 1, 1);
    cycle(0, 1, 0);
    for (int g = 0; g < 3; g++) begin
      cycle(0, 0, g[0]);
      check("gap_state_a", st[0], 2);
      check("gap_mealy_a", obs_m[0], 0);
    end
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    check("gap_hit_a", obs_m[0], 1);
    check("gap_count_a", hc[0], 1);

    // Saturation of the 2-bit counter.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 1);
      check("sat_mealy_c", obs_m[2], int'(k >= 1));
    end
    check("sat_count_c", hc[2], 3);

    // Clear wins over a valid bit that would otherwise advance.
    do_reset();
    cycle(0, 1, 1); cycle(0, 1, 0); cycle(0, 1, 1);
    cycle(1, 1, 1);
    check("clr_mealy_a", obs_m[0], 0);
    check("clr_state_a", st[0], 0);
    check("clr_count_a", hc[0], 0);
    cycle(0, 1, 1); cycle(0, 1, 0); cycle(0, 1, 1); cycle(0, 1, 1);
    check("clr_hit_a", obs_m[0], 1);
    check("clr_count2_a", hc[0], 1);

    // Asynchronous reset mid-cycle while at S3 with a nonzero count.
    do_reset();
    cycle(0, 1, 1); cycle(0, 1, 0); cycle(0, 1, 1); cycle(0, 1, 1);
    cycle(0, 1, 1); cycle(0, 1, 0); cycle(0, 1, 1);
    check("pre_rst_state_a", st[0], 3);
    check("pre_rst_count_a", hc[0], 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_state_a", st[0], 0);
    check("arst_moore_a", moh[0], 0);
    check("arst_count_a", hc[0], 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0; din_valid = 1'b0;
    cycle(0, 1, 0); cycle(0, 1, 1); cycle(0, 1, 1);
    check("post_rst_mealy_a", obs_m[0], 0);
    check("post_rst_count_a", hc[0], 0);

    // Randomised stream against the history model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
            1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
